seg_display_arbiter: RTL and testbench

Shares the single 8-digit seven-segment display between several display requesters: user entry, admin entry, and alarm/countdown status. It performs fixed-priority arbitration with a minimum ownership hold, and drives the multiplexed digit scan. The block sits between the password entry / status logic and the board `segment_display`/`AN` pins, and replaces the per-state output muxing in the top level.

---
 rtl/seg_arb_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 36 +++
 rtl/seg_display_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_arb_pkg.sv
// ============================================================================
// Module      : seg_arb_pkg
// Description : Shared types and constants for the seven-segment arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN    = 2'd1,
      SWITCH = 2'd2
   } arb_state_t;

   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   // Segment patterns, bit order gfedcba, active high
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : 4-bit digit code to gfedcba segment pattern (10 = dash).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
   import seg_arb_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         4'd0:       o_seg = SEG_0;
         4'd1:       o_seg = SEG_1;
         4'd2:       o_seg = SEG_2;
         4'd3:       o_seg = SEG_3;
         4'd4:       o_seg = SEG_4;
         4'd5:       o_seg = SEG_5;
         4'd6:       o_seg = SEG_6;
         4'd7:       o_seg = SEG_7;
         4'd8:       o_seg = SEG_8;
         4'd9:       o_seg = SEG_9;
         CODE_DASH:  o_seg = SEG_DASH;
         CODE_BLANK: o_seg = SEG_BLANK;
         default:    o_seg = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module      : seg_display_arbiter
// Description : Fixed-priority owner arbitration with minimum hold and
//               multiplexed 8-digit scan. Optional macro SEG_ARB_BLINK_EN
//               blinks the display while the top requester owns it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter
   import seg_arb_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int SCAN_DIV    = 250000,
   parameter int HOLD_TICKS  = 400,
   parameter int BLINK_TICKS = 200
) (
   input  logic                    clk_100Mhz,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*32-1:0]   digits,
   input  logic [NUM_REQ*8-1:0]    digit_en,
   output logic [NUM_REQ-1:0]      grant,
   output logic [6:0]              segment_display,
   output logic [7:0]              AN,
   output logic                    scan_tick
);

   localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_HW = $clog2(HOLD_TICKS + 1);
   localparam logic [c_PW-1:0]    c_PRESC_MAX = c_PW'(SCAN_DIV - 1);
   localparam logic [c_HW-1:0]    c_HOLD_MAX  = c_HW'(HOLD_TICKS);
   localparam logic [c_IW-1:0]    c_TOP       = c_IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] c_ONE       = NUM_REQ'(1);

   arb_state_t          r_state, w_state_nxt;
   logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
   logic [c_PW-1:0]     r_presc;
   logic [2:0]          r_idx;
   logic [c_HW-1:0]     r_hold;
   logic [7:0]          r_an;
   logic [6:0]          r_seg;
   logic                w_tick;
   logic                w_any_req;
   logic                w_own_req;
   logic                w_grant_chg;
   logic                w_blink_off;
   logic [c_IW-1:0]     w_own_idx;
   logic [c_IW-1:0]     w_hi_idx;
   logic [31:0]         w_sel_digits;
   logic [7:0]          w_sel_en;
   logic [3:0]          w_code;
   logic [6:0]          w_seg;
   logic [7:0]          w_an_raw;

   assign w_tick    = (r_presc == c_PRESC_MAX);
   assign w_any_req = |req;
   assign w_own_req = |(req & r_grant);

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick)
            r_idx <= r_idx + 3'd1;
      end
   end

   // Owner slice select and highest pending request
   always_comb begin
      w_own_idx    = '0;
      w_hi_idx     = '0;
      w_sel_digits = '0;
      w_sel_en     = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (r_grant[r]) begin
            w_own_idx    = c_IW'(r);
            w_sel_digits = digits[r*32 +: 32];
            w_sel_en     = digit_en[r*8 +: 8];
         end
         if (req[r])
            w_hi_idx = c_IW'(r);
      end
   end

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         r_state <= IDLE;
         r_grant <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nxt = OWN;
               w_grant_nxt = c_ONE << w_hi_idx;
            end
         end
         OWN: begin
            // Release wins over any simultaneous higher request
            if (!w_own_req) begin
               w_state_nxt = SWITCH;
               w_grant_nxt = '0;
            end else if ((w_hi_idx > w_own_idx) &&
                         ((w_hi_idx == c_TOP) || (r_hold == c_HOLD_MAX))) begin
               w_grant_nxt = c_ONE << w_hi_idx;
            end
         end
         SWITCH: begin
            if (w_tick) begin
               if (w_any_req) begin
                  w_state_nxt = OWN;
                  w_grant_nxt = c_ONE << w_hi_idx;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   assign w_grant_chg = (w_grant_nxt != r_grant);

   always_ff @(posedge clk_100Mhz) begin
      if (reset || w_grant_chg)
         r_hold <= '0;
      else if (w_tick && (r_hold != c_HOLD_MAX))
         r_hold <= r_hold + 1'b1;
   end

`ifdef SEG_ARB_BLINK_EN
   localparam int c_BW = (BLINK_TICKS > 1) ? $clog2(2 * BLINK_TICKS) : 1;
   localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(2 * BLINK_TICKS - 1);
   localparam logic [c_BW-1:0] c_BLINK_HALF = c_BW'(BLINK_TICKS);

   logic [c_BW-1:0] r_blink;

   always_ff @(posedge clk_100Mhz) begin
      if (reset || w_grant_chg)
         r_blink <= '0;
      else if (w_tick && r_grant[NUM_REQ-1])
         r_blink <= (r_blink == c_BLINK_LAST) ? '0 : r_blink + 1'b1;
   end

   // Visible half first, then dark half
   assign w_blink_off = r_grant[NUM_REQ-1] && (r_blink >= c_BLINK_HALF);
`else
   assign w_blink_off = 1'b0;
`endif

   assign w_code   = w_sel_digits[{r_idx, 2'b00} +: 4];
   assign w_an_raw = w_sel_en & (8'd1 << r_idx);

   seg7_decode u_decode (
      .i_code (w_code),
      .o_seg  (w_seg)
   );

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         r_an  <= '0;
         r_seg <= '0;
      end else if (w_tick) begin
         if (|r_grant) begin
            r_an  <= w_blink_off ? 8'd0 : w_an_raw;
            r_seg <= w_seg;
         end else begin
            r_an  <= '0;
            r_seg <= '0;
         end
      end
   end

   assign grant           = r_grant;
   assign AN              = r_an;
   assign segment_display = r_seg;
   assign scan_tick       = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
// Module      : tb_seg_display_arbiter
// Description : Directed self-checking bench for seg_display_arbiter
//               (blink expectations follow SEG_ARB_BLINK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [95:0] digits;
   logic [23:0] digit_en;
   logic [2:0]  grant;
   logic [6:0]  segment_display;
   logic [7:0]  AN;
   logic        scan_tick;

   int          n_tests;
   int          n_fail;
   int          m_presc;
   logic [2:0]  m_idx;

   typedef struct {
      logic [3:0] code;
      logic       en;
      logic [6:0] seg;
   } vec_t;

   vec_t vecs [16];

   seg_display_arbiter #(
      .NUM_REQ     (3),
      .SCAN_DIV    (4),
      .HOLD_TICKS  (3),
      .BLINK_TICKS (2)
   ) dut (
      .clk_100Mhz      (clk),
      .reset           (reset),
      .req             (req),
      .digits          (digits),
      .digit_en        (digit_en),
      .grant           (grant),
      .segment_display (segment_display),
      .AN              (AN),
      .scan_tick       (scan_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; the prescaler model follows what the DUT will sample
   task automatic step();
      if (reset) begin
         m_presc = 0;
         m_idx   = 3'd0;
      end else if (m_presc == 3) begin
         m_presc = 0;
         m_idx   = m_idx + 3'd1;
      end else begin
         m_presc = m_presc + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick_step(output logic [2:0] ti);
      while (m_presc != 3) step();
      chk("scan_tick_high", 32'(scan_tick), 32'd1);
      ti = m_idx;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 3'b000;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [2:0] ti;
      logic       vis;
      n_tests  = 0;
      n_fail   = 0;
      m_presc  = 0;
      m_idx    = 3'd0;
      reset    = 1'b1;
      req      = 3'b000;
      digits   = '0;
      digit_en = '0;

      vecs[0]  = '{4'd0,  1'b1, 7'h3F};
      vecs[1]  = '{4'd1,  1'b1, 7'h06};
      vecs[2]  = '{4'd2,  1'b1, 7'h5B};
      vecs[3]  = '{4'd3,  1'b0, 7'h4F};
      vecs[4]  = '{4'd4,  1'b1, 7'h66};
      vecs[5]  = '{4'd5,  1'b1, 7'h6D};
      vecs[6]  = '{4'd6,  1'b1, 7'h7D};
      vecs[7]  = '{4'd7,  1'b1, 7'h07};
      vecs[8]  = '{4'd8,  1'b1, 7'h7F};
      vecs[9]  = '{4'd9,  1'b1, 7'h6F};
      vecs[10] = '{4'd10, 1'b0, 7'h40};
      vecs[11] = '{4'd11, 1'b1, 7'h00};
      vecs[12] = '{4'd12, 1'b1, 7'h00};
      vecs[13] = '{4'd13, 1'b1, 7'h00};
      vecs[14] = '{4'd14, 1'b0, 7'h00};
      vecs[15] = '{4'd15, 1'b1, 7'h00};

      // Reset state and idle scan
      do_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_an", 32'(AN), 32'd0);
      chk("rst_seg", 32'(segment_display), 32'd0);
      chk("rst_tick", 32'(scan_tick), 32'd0);
      for (int k = 0; k < 40; k++) begin
         step();
         chk("idle_grant", 32'(grant), 32'd0);
         chk("idle_an", 32'(AN), 32'd0);
         chk("idle_tick", 32'(scan_tick), 32'(m_presc == 3));
      end

      // Single owner walks all eight digits
      do_reset();
      digits[31:0]  = 32'h8765_4321;
      digit_en[7:0] = 8'hFF;
      req           = 3'b001;
      step();
      chk("single_grant", 32'(grant), 32'd1);
      for (int t = 0; t < 8; t++) begin
         tick_step(ti);
         chk("walk_idx", 32'(ti), 32'(t));
         chk("walk_an", 32'(AN), 32'(8'd1 << t));
         chk("walk_seg", 32'(segment_display), 32'(vecs[t+1].seg));
      end

      // Decode table with per-digit enable
      for (int i = 0; i < 16; i++) begin
         digits[31:0]  = {8{vecs[i].code}};
         digit_en[7:0] = {8{vecs[i].en}};
         tick_step(ti);
         chk("dec_an", 32'(AN), vecs[i].en ? 32'(8'd1 << ti) : 32'd0);
         chk("dec_seg", 32'(segment_display), 32'(vecs[i].seg));
      end
      // Inputs changed between ticks must not show through
      digits[31:0]  = 32'h8888_8888;
      digit_en[7:0] = 8'h00;
      step();
      chk("between_seg", 32'(segment_display), 32'h00);
      chk("between_an", 32'(AN), 32'(8'd1 << (m_idx - 3'd1)));

      // Hold then preempt by requester 1
      do_reset();
      digits   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      digit_en = 24'hFF_FFFF;
      req      = 3'b001;
      step();
      chk("hold_grant0", 32'(grant), 32'd1);
      tick_step(ti);
      req = 3'b011;
      tick_step(ti);
      chk("hold_wait", 32'(grant), 32'd1);
      tick_step(ti);
      chk("hold_sat", 32'(grant), 32'd1);
      step();
      chk("hold_preempt", 32'(grant), 32'd2);
      tick_step(ti);
      chk("own1_seg", 32'(segment_display), 32'h5B);
      chk("own1_an", 32'(AN), 32'(8'd1 << ti));

      // Top preemption ignores hold, then blink pattern
      req = 3'b111;
      step();
      chk("top_preempt", 32'(grant), 32'd4);
      for (int k = 0; k < 8; k++) begin
         tick_step(ti);
`ifdef SEG_ARB_BLINK_EN
         vis = ((k % 4) < 2);
`else
         vis = 1'b1;
`endif
         chk("blink_an", 32'(AN), vis ? 32'(8'd1 << ti) : 32'd0);
         chk("blink_seg", 32'(segment_display), 32'h4F);
      end

      // Release gap with one blank tick
      req = 3'b001;
      step();
      chk("gap_release", 32'(grant), 32'd0);
      while (m_presc != 3) begin
         step();
         chk("gap_hold", 32'(grant), 32'd0);
      end
      chk("gap_tick", 32'(scan_tick), 32'd1);
      step();
      chk("gap_regrant", 32'(grant), 32'd1);
      chk("gap_blank_an", 32'(AN), 32'd0);
      chk("gap_blank_seg", 32'(segment_display), 32'd0);
      tick_step(ti);
      chk("gap_show_an", 32'(AN), 32'(8'd1 << ti));
      chk("gap_show_seg", 32'(segment_display), 32'h06);

      // Release and top request in the same cycle
      req = 3'b100;
      step();
      chk("reltop_switch", 32'(grant), 32'd0);
      while (m_presc != 3) begin
         step();
         chk("reltop_hold", 32'(grant), 32'd0);
      end
      step();
      chk("reltop_grant", 32'(grant), 32'd4);

      // Reset discards a pending switch
      req = 3'b000;
      step();
      chk("rst_sw_grant", 32'(grant), 32'd0);
      req   = 3'b001;
      reset = 1'b1;
      step();
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_an", 32'(AN), 32'd0);
      chk("midrst_seg", 32'(segment_display), 32'd0);
      chk("midrst_tick", 32'(scan_tick), 32'd0);
      reset = 1'b0;
      step();
      chk("postrst_grant", 32'(grant), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
